// File: rtl/cep_uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding and
// bit-period arithmetic derived from the clock and bit-rate parameters.
package cep_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Counter width that stays at least one bit wide for degenerate ranges.
    function automatic int count_width(input int range_len);
        return (range_len > 1) ? $clog2(range_len) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-in first-out byte buffer feeding the transmitter; first-word
// fall-through, so rd_data always shows the head entry.
module uart_tx_fifo
    import cep_uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    rd_en,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = count_width(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]             wr_ptr_r;
    logic [AW:0]             rd_ptr_r;
    logic [PAYLOAD_BITS-1:0] mem_r [FIFO_DEPTH];
    logic                    wr_ok_s;
    logic                    rd_ok_s;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update: accept and pop on the same edge both take effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1-style frames (configurable payload and stop
// bits) sent LSB first, back-to-back while enabled and data is queued.
module uart_tx
    import cep_uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    uart_txd,
    output logic                    uart_tx_busy
);

    localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W = count_width(CPB);
    localparam int IDX_W = count_width(PAYLOAD_BITS);

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t               state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic                    txd_r;

    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [PAYLOAD_BITS-1:0] fifo_rd_data_s;
    logic                    bit_done_s;
    logic                    pop_s;

    uart_tx_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign bit_done_s   = (cnt_r == {CNT_W{1'b0}});
    assign tx_ready     = !fifo_full_s;
    assign uart_txd     = txd_r;
    assign uart_tx_busy = !((state_r == IDLE) && fifo_empty_s);

    // Frame start decision: from IDLE, or straight out of the final stop bit.
    always_comb begin
        pop_s = 1'b0;
        if (uart_tx_en && !fifo_empty_s) begin
            case (state_r)
                IDLE:    pop_s = 1'b1;
                STOP:    pop_s = bit_done_s && (idx_r == LAST_STOP);
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Transmit FSM; the line is always driven from txd_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            txd_r   <= 1'b1;
        end else if (pop_s) begin
            state_r <= START;
            cnt_r   <= CNT_LOAD;
            idx_r   <= '0;
            shift_r <= fifo_rd_data_s;
            txd_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    txd_r <= 1'b1;
                end
                START: begin
                    if (bit_done_s) begin
                        state_r <= DATA;
                        cnt_r   <= CNT_LOAD;
                        idx_r   <= '0;
                        txd_r   <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        cnt_r <= CNT_LOAD;
                        if (idx_r == LAST_DATA) begin
                            state_r <= STOP;
                            idx_r   <= '0;
                            txd_r   <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + IDX_ONE;
                            txd_r   <= shift_r[1];
                            shift_r <= {1'b0, shift_r[PAYLOAD_BITS-1:1]};
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        cnt_r <= CNT_LOAD;
                        if (idx_r == LAST_STOP) begin
                            state_r <= IDLE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule
